// File: rtl/mem_axi_dpram_sync_pipe.sv
// Simple dual-port synchronous RAM with byte strobes, 1- or 2-cycle read pipeline,
// selectable collision mode and read-side byte masking. Optional parity: MEM_DPRAM_PARITY_EN.
module mem_axi_dpram_sync_pipe #(
    parameter int WIDTH_AD    = 10,
    parameter int WIDTH_DA    = 32,
    parameter int WIDTH_DS    = WIDTH_DA / 8,
    parameter int WIDTH_DSB   = $clog2(WIDTH_DS),
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic [WIDTH_AD-1:0] WADDR,
    input  logic [WIDTH_DA-1:0] WDATA,
    input  logic [WIDTH_DS-1:0] WSTRB,
    input  logic                WEN,
    input  logic                PERR_INJ,
    input  logic [WIDTH_AD-1:0] RADDR,
    input  logic [WIDTH_DS-1:0] RSTRB,
    input  logic                REN,
    output logic [WIDTH_DA-1:0] RDATA,
    output logic                RVALID,
    output logic [WIDTH_DS-1:0] RERR
);

    localparam int WIDTH_WI = WIDTH_AD - WIDTH_DSB;
    localparam int DEPTH    = 1 << WIDTH_WI;

    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
        $error("mem_axi_dpram_sync_pipe: RD_LATENCY must be 1 or 2");
    end

    logic [WIDTH_DA-1:0] mem_q [DEPTH];
    logic [WIDTH_WI-1:0] widx;
    logic [WIDTH_WI-1:0] ridx;
    logic                collide;

    assign widx    = WADDR[WIDTH_AD-1:WIDTH_DSB];
    assign ridx    = RADDR[WIDTH_AD-1:WIDTH_DSB];
    assign collide = WEN && (widx == ridx);

    // Storage is never reset; only the read pipeline is.
    always @(posedge CLK) begin
        if (WEN) begin
            for (int i = 0; i < WIDTH_DS; i++) begin
                if (WSTRB[i]) begin
                    mem_q[widx][8*i +: 8] <= WDATA[8*i +: 8];
                end
            end
        end
    end

`ifdef MEM_DPRAM_PARITY_EN
    logic [WIDTH_DS-1:0] par_q [DEPTH];

    always @(posedge CLK) begin
        if (WEN) begin
            for (int i = 0; i < WIDTH_DS; i++) begin
                if (WSTRB[i]) begin
                    par_q[widx][i] <= (^WDATA[8*i +: 8]) ^ PERR_INJ;
                end
            end
        end
    end
`endif

    logic [WIDTH_DA-1:0] rd_data_d;
    logic [WIDTH_DS-1:0] rd_err_d;
    logic [7:0]          rd_lane;
    logic                rd_par;

    always_comb begin
        rd_data_d = '0;
        rd_err_d  = '0;
        rd_lane   = '0;
        rd_par    = 1'b0;
        for (int i = 0; i < WIDTH_DS; i++) begin
            rd_lane = mem_q[ridx][8*i +: 8];
`ifdef MEM_DPRAM_PARITY_EN
            rd_par  = par_q[ridx][i];
`endif
            // Write-first forwards the strobed lanes with the parity being written now.
            if ((WRITE_FIRST != 0) && collide && WSTRB[i]) begin
                rd_lane = WDATA[8*i +: 8];
                rd_par  = (^WDATA[8*i +: 8]) ^ PERR_INJ;
            end
            if (RSTRB[i]) begin
                rd_data_d[8*i +: 8] = rd_lane;
`ifdef MEM_DPRAM_PARITY_EN
                rd_err_d[i] = rd_par ^ (^rd_lane);
`endif
            end
        end
    end

    logic                s1_valid_q;
    logic [WIDTH_DA-1:0] s1_data_q;
    logic [WIDTH_DS-1:0] s1_err_q;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_err_q   <= '0;
        end else begin
            s1_valid_q <= REN;
            s1_err_q   <= REN ? rd_err_d : '0;
            if (REN) begin
                s1_data_q <= rd_data_d;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                s2_valid_q;
        logic [WIDTH_DA-1:0] s2_data_q;
        logic [WIDTH_DS-1:0] s2_err_q;

        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
                s2_err_q   <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_err_q   <= s1_err_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign RVALID = s2_valid_q;
        assign RDATA  = s2_data_q;
        assign RERR   = s2_err_q;
    end else begin : g_lat1
        assign RVALID = s1_valid_q;
        assign RDATA  = s1_data_q;
        assign RERR   = s1_err_q;
    end

    // Byte-offset address bits and, without parity, PERR_INJ carry no function.
    logic unused_ok;
    assign unused_ok = ^{PERR_INJ, WADDR, RADDR};

`ifndef SYNTHESIS
    // Backdoor access for bench models; the write lands in the current time step.
    task automatic write(input logic [WIDTH_AD-1:0] addr,
                         input logic [WIDTH_DA-1:0] data,
                         input logic [WIDTH_DS-1:0] be);
        for (int i = 0; i < WIDTH_DS; i++) begin
            if (be[i]) begin
                mem_q[addr[WIDTH_AD-1:WIDTH_DSB]][8*i +: 8] <= data[8*i +: 8];
`ifdef MEM_DPRAM_PARITY_EN
                par_q[addr[WIDTH_AD-1:WIDTH_DSB]][i] <= ^data[8*i +: 8];
`endif
            end
        end
    endtask

    task automatic read(input  logic [WIDTH_AD-1:0] addr,
                        output logic [WIDTH_DA-1:0] data);
        data = mem_q[addr[WIDTH_AD-1:WIDTH_DSB]];
    endtask
`endif

endmodule

// File: tb/tb_mem_axi_dpram_sync_pipe.sv
// Scoreboard bench for mem_axi_dpram_sync_pipe: four instances (latency 1/2, both
// collision modes, 64-bit width) checked by a negedge monitor against queued expectations.
module tb_mem_axi_dpram_sync_pipe;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [9:0]  waddr, raddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb, rstrb;
    logic        wen, ren, perr;

    logic [9:0]  waddr_d, raddr_d;
    logic [63:0] wdata_d;
    logic [7:0]  wstrb_d, rstrb_d;
    logic        wen_d, ren_d, perr_d;

    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic [63:0] rdata_d;
    logic        rvalid_a, rvalid_b, rvalid_c, rvalid_d;
    logic [3:0]  rerr_a, rerr_b, rerr_c;
    logic [7:0]  rerr_d;

    exp_t sbq [4][$];
    int   lat [4] = '{1, 1, 2, 1};
    int   cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_axi_dpram_sync_pipe #(.RD_LATENCY(1), .WRITE_FIRST(1)) u_a (
        .CLK(clk), .RESETn(rst_n), .WADDR(waddr), .WDATA(wdata), .WSTRB(wstrb), .WEN(wen),
        .PERR_INJ(perr), .RADDR(raddr), .RSTRB(rstrb), .REN(ren),
        .RDATA(rdata_a), .RVALID(rvalid_a), .RERR(rerr_a));

    mem_axi_dpram_sync_pipe #(.RD_LATENCY(1), .WRITE_FIRST(0)) u_b (
        .CLK(clk), .RESETn(rst_n), .WADDR(waddr), .WDATA(wdata), .WSTRB(wstrb), .WEN(wen),
        .PERR_INJ(perr), .RADDR(raddr), .RSTRB(rstrb), .REN(ren),
        .RDATA(rdata_b), .RVALID(rvalid_b), .RERR(rerr_b));

    mem_axi_dpram_sync_pipe #(.RD_LATENCY(2), .WRITE_FIRST(1)) u_c (
        .CLK(clk), .RESETn(rst_n), .WADDR(waddr), .WDATA(wdata), .WSTRB(wstrb), .WEN(wen),
        .PERR_INJ(perr), .RADDR(raddr), .RSTRB(rstrb), .REN(ren),
        .RDATA(rdata_c), .RVALID(rvalid_c), .RERR(rerr_c));

    mem_axi_dpram_sync_pipe #(.WIDTH_DA(64), .RD_LATENCY(1), .WRITE_FIRST(1)) u_d (
        .CLK(clk), .RESETn(rst_n), .WADDR(waddr_d), .WDATA(wdata_d), .WSTRB(wstrb_d), .WEN(wen_d),
        .PERR_INJ(perr_d), .RADDR(raddr_d), .RSTRB(rstrb_d), .REN(ren_d),
        .RDATA(rdata_d), .RVALID(rvalid_d), .RERR(rerr_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic mon(input int k, input logic v, input logic [63:0] d, input logic [7:0] e);
        exp_t x;
        if (v) begin
            n_cmp++;
            if (sbq[k].size() == 0) begin
                n_bad++;
                $display("FAIL stale_beat inst%0d: got RVALID with data %h at cycle %0d, required no beat", k, d, cnt);
            end else begin
                x = sbq[k].pop_front();
                if (d !== x.data || e !== x.err || cnt != x.cyc) begin
                    n_bad++;
                    $display("FAIL rdata inst%0d: got data %h err %h cycle %0d, required data %h err %h cycle %0d",
                             k, d, e, cnt, x.data, x.err, x.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rvalid_a, {32'b0, rdata_a}, {4'b0, rerr_a});
        mon(1, rvalid_b, {32'b0, rdata_b}, {4'b0, rerr_b});
        mon(2, rvalid_c, {32'b0, rdata_c}, {4'b0, rerr_c});
        mon(3, rvalid_d, rdata_d, rerr_d);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [63:0] d, input logic [7:0] e);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.cyc  = cnt + lat[k];
        sbq[k].push_back(x);
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s, input logic p);
        waddr = a; wdata = d; wstrb = s; perr = p; wen = 1'b1;
        tick();
        wen = 1'b0; perr = 1'b0;
    endtask

    // Issue a read on the three 32-bit instances; ea/eb/ec are per-instance expectations.
    task automatic issue_rd(input logic [9:0] a, input logic [3:0] s,
                            input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                            input logic [3:0] e);
        raddr = a; rstrb = s; ren = 1'b1;
        push(0, {32'b0, ea}, {4'b0, e});
        push(1, {32'b0, eb}, {4'b0, e});
        push(2, {32'b0, ec}, {4'b0, e});
    endtask

    task automatic rd(input logic [9:0] a, input logic [3:0] s, input logic [31:0] ex, input logic [3:0] e);
        issue_rd(a, s, ex, ex, ex, e);
        tick();
        ren = 1'b0;
    endtask

    task automatic drop_inflight();
        exp_t x;
        for (int k = 0; k < 4; k++) begin
            while (sbq[k].size() > 0) begin
                x = sbq[k].pop_front();
                if (x.cyc < cnt) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_beat inst%0d: got no beat at cycle %0d, required data %h", k, x.cyc, x.data);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        waddr = '0; wdata = '0; wstrb = '0; wen = 1'b0; perr = 1'b0;
        raddr = '0; rstrb = '0; ren = 1'b0;
        waddr_d = '0; wdata_d = '0; wstrb_d = '0; wen_d = 1'b0; perr_d = 1'b0;
        raddr_d = '0; rstrb_d = '0; ren_d = 1'b0;

        repeat (3) tick();
        chk("reset_rdata_a", {32'b0, rdata_a}, 64'h0);
        chk("reset_rvalid_a", {63'b0, rvalid_a}, 64'h0);
        chk("reset_rdata_c", {32'b0, rdata_c}, 64'h0);
        chk("reset_rvalid_c", {63'b0, rvalid_c}, 64'h0);
        chk("reset_rdata_d", rdata_d, 64'h0);
        chk("reset_rvalid_d", {63'b0, rvalid_d}, 64'h0);
        rst_n = 1'b1;
        tick();

        // Full write then read at an unaligned byte address of the same word
        wr(10'h010, 32'hDEADBEEF, 4'hF, 1'b0);
        rd(10'h013, 4'hF, 32'hDEADBEEF, 4'h0);

        // Partial write merge and read-side masking
        wr(10'h020, 32'h11223344, 4'hF, 1'b0);
        wr(10'h020, 32'hAABBCCDD, 4'h5, 1'b0);
        rd(10'h020, 4'hF, 32'h11BB33DD, 4'h0);
        rd(10'h020, 4'h3, 32'h000033DD, 4'h0);
        wr(10'h020, 32'h99999999, 4'h0, 1'b0);
        rd(10'h020, 4'hF, 32'h11BB33DD, 4'h0);

        // Same-cycle collision: write-first forwards strobed lanes, read-first sees old
        wr(10'h030, 32'h00000000, 4'hF, 1'b0);
        waddr = 10'h030; wdata = 32'hCAFEF00D; wstrb = 4'h3; wen = 1'b1;
        issue_rd(10'h030, 4'hF, 32'h0000F00D, 32'h00000000, 32'h0000F00D, 4'h0);
        tick();
        wen = 1'b0; ren = 1'b0;
        rd(10'h030, 4'hF, 32'h0000F00D, 4'h0);

        // A write the cycle after a read must not disturb the captured data
        issue_rd(10'h030, 4'hF, 32'h0000F00D, 32'h0000F00D, 32'h0000F00D, 4'h0);
        tick();
        ren = 1'b0;
        wr(10'h030, 32'hFFFFFFFF, 4'hF, 1'b0);
        rd(10'h030, 4'hF, 32'hFFFFFFFF, 4'h0);

        // Different word in the same cycle: no interaction
        waddr = 10'h034; wdata = 32'h12345678; wstrb = 4'hF; wen = 1'b1;
        issue_rd(10'h030, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0);
        tick();
        wen = 1'b0; ren = 1'b0;

        // Back-to-back streaming of words 0..7
        for (int i = 0; i < 8; i++) wr(10'(i * 4), 32'(i), 4'hF, 1'b0);
        for (int i = 0; i < 8; i++) begin
            issue_rd(10'(i * 4), 4'hF, 32'(i), 32'(i), 32'(i), 4'h0);
            tick();
        end
        ren = 1'b0;
        repeat (3) tick();

        // Reset mid-burst: in-flight beats are dropped, nothing stale afterwards
        for (int i = 0; i < 4; i++) begin
            issue_rd(10'(i * 4), 4'hF, 32'(i), 32'(i), 32'(i), 4'h0);
            tick();
        end
        ren = 1'b0;
        rst_n = 1'b0;
        drop_inflight();
        #1;
        chk("midreset_rvalid_a", {63'b0, rvalid_a}, 64'h0);
        chk("midreset_rvalid_b", {63'b0, rvalid_b}, 64'h0);
        chk("midreset_rvalid_c", {63'b0, rvalid_c}, 64'h0);
        chk("midreset_rdata_c", {32'b0, rdata_c}, 64'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        rd(10'h014, 4'hF, 32'h00000005, 4'h0);

        // 64-bit instance: upper-lane strobes only
        waddr_d = 10'h008; wdata_d = 64'h0; wstrb_d = 8'hFF; wen_d = 1'b1;
        tick();
        wdata_d = 64'h0123456789ABCDEF; wstrb_d = 8'hF0;
        tick();
        wen_d = 1'b0;
        raddr_d = 10'h008; rstrb_d = 8'hFF; ren_d = 1'b1;
        push(3, 64'h0123456700000000, 8'h00);
        tick();
        rstrb_d = 8'h80;
        push(3, 64'h0100000000000000, 8'h00);
        tick();
        ren_d = 1'b0;

`ifdef MEM_DPRAM_PARITY_EN
        wr(10'h040, 32'h00000000, 4'hF, 1'b0);
        wr(10'h040, 32'h000000FF, 4'h1, 1'b1);
        rd(10'h040, 4'hF, 32'h000000FF, 4'h1);
        rd(10'h040, 4'hE, 32'h00000000, 4'h0);
        wr(10'h040, 32'h000000FF, 4'h1, 1'b0);
        rd(10'h040, 4'hF, 32'h000000FF, 4'h0);
`endif

        repeat (6) tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (sbq[k].size() != 0) begin
                n_bad++;
                $display("FAIL drain inst%0d: got %0d beats outstanding, required 0", k, sbq[k].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
